// File: rtl/cache_control.sv
// cache_control: controller FSM for a 2-way set-associative write-back L1 cache.
// Decides hit/miss, sequences dirty writeback and line allocate, owns LRU bits.
module cache_control #(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [1:0]       hit,
    input  logic [1:0]       valid,
    input  logic [1:0]       dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [1:0]       load_data,
    output logic [1:0]       load_tag,
    output logic [1:0]       set_dirty,
    output logic [1:0]       clr_dirty,
    output logic             data_src,
    output logic             addr_src,
    output logic             way_sel
);

    localparam int SETS = 2 ** IDX_W;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SETS-1:0] r_lru;
    logic            r_victim;

    logic       w_req;
    logic       w_hit_way;
    logic [1:0] w_hit_oh;
    logic       w_miss_vic;
    logic [1:0] w_vic_oh;
    logic       w_lru_we;
    logic       w_vic_we;

    // Hit way (way 0 wins on an illegal double hit) and miss victim choice
    always_comb begin
        w_req      = mem_read | mem_write;
        w_hit_way  = ~hit[0];
        w_hit_oh   = w_hit_way ? 2'b10 : 2'b01;
        w_vic_oh   = r_victim ? 2'b10 : 2'b01;
        if (!valid[0]) begin
            w_miss_vic = 1'b0;
        end else if (!valid[1]) begin
            w_miss_vic = 1'b1;
        end else begin
            w_miss_vic = r_lru[set_idx];
        end
    end

    // Next state and datapath controls; everything held low during reset
    always_comb begin
        w_next     = r_state;
        w_lru_we   = 1'b0;
        w_vic_we   = 1'b0;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_data  = 2'b00;
        load_tag   = 2'b00;
        set_dirty  = 2'b00;
        clr_dirty  = 2'b00;
        data_src   = 1'b0;
        addr_src   = 1'b0;
        way_sel    = 1'b0;
        case (r_state)
            CHECK: begin
                if (w_req && (|hit)) begin
                    mem_resp = 1'b1;
                    way_sel  = w_hit_way;
                    w_lru_we = 1'b1;
                    if (mem_write) begin
                        load_data = w_hit_oh;
                        set_dirty = w_hit_oh;
                    end
                end else if (w_req) begin
                    w_vic_we = 1'b1;
                    if (valid[w_miss_vic] && dirty[w_miss_vic]) begin
                        w_next = WRITEBACK;
                    end else begin
                        w_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                addr_src   = 1'b1;
                way_sel    = r_victim;
                if (pmem_resp) begin
                    clr_dirty = w_vic_oh;
                    w_next    = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data = w_vic_oh;
                    load_tag  = w_vic_oh;
                    clr_dirty = w_vic_oh;
                    data_src  = 1'b1;
                    w_next    = CHECK;
                end
            end
            default: begin
                w_next = CHECK;
            end
        endcase
        if (!rst_n) begin
            w_lru_we   = 1'b0;
            w_vic_we   = 1'b0;
            mem_resp   = 1'b0;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
            load_data  = 2'b00;
            load_tag   = 2'b00;
            set_dirty  = 2'b00;
            clr_dirty  = 2'b00;
            data_src   = 1'b0;
            addr_src   = 1'b0;
            way_sel    = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CHECK;
        end else begin
            r_state <= w_next;
        end
    end

    // LRU bit of the set points at the way not just used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lru <= '0;
        end else if (w_lru_we) begin
            r_lru[set_idx] <= ~w_hit_way;
        end
    end

    // Victim way latched in the miss cycle, steers writeback and allocate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_victim <= 1'b0;
        end else if (w_vic_we) begin
            r_victim <= w_miss_vic;
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed bench; expected output events go to a queue,
// a negedge monitor pops and compares each new non-idle output pattern.
module tb_cache_control;

    typedef struct packed {
        logic       resp;
        logic       pr;
        logic       pw;
        logic [1:0] ld;
        logic [1:0] lt;
        logic [1:0] sd;
        logic [1:0] cd;
        logic       ds;
        logic       asrc;
        logic       ws;
    } ob_t;

    logic       clk;
    logic       rst_n;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] set_idx;
    logic [1:0] hit;
    logic [1:0] valid;
    logic [1:0] dirty;
    logic       pmem_resp;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic [1:0] load_data;
    logic [1:0] load_tag;
    logic [1:0] set_dirty;
    logic [1:0] clr_dirty;
    logic       data_src;
    logic       addr_src;
    logic       way_sel;

    int  n_vec = 0;
    int  n_err = 0;
    int  n_ev  = 0;
    ob_t q[$];
    ob_t prev = '0;

    cache_control #(.IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .set_idx(set_idx), .hit(hit), .valid(valid), .dirty(dirty),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .load_data(load_data), .load_tag(load_tag),
        .set_dirty(set_dirty), .clr_dirty(clr_dirty),
        .data_src(data_src), .addr_src(addr_src), .way_sel(way_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ob_t cur_out();
        ob_t b;
        b.resp = mem_resp;
        b.pr   = pmem_read;
        b.pw   = pmem_write;
        b.ld   = load_data;
        b.lt   = load_tag;
        b.sd   = set_dirty;
        b.cd   = clr_dirty;
        b.ds   = data_src;
        b.asrc = addr_src;
        b.ws   = way_sel;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: each change to a non-idle output pattern is one event
    always @(negedge clk) begin
        ob_t c;
        c = cur_out();
        if (rst_n && c != prev && c != '0) begin
            n_ev++;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ev%0d: got %h want none", n_ev, c);
            end else begin
                chk($sformatf("ev%0d", n_ev), 32'(c), 32'(q.pop_front()));
            end
        end
        prev = c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 2'b00;
        pmem_resp = 1'b0;
    endtask

    task automatic do_hit(input logic [2:0] s, input logic rd, input logic wr,
                          input logic [1:0] h, input logic [1:0] v,
                          input logic w);
        ob_t e;
        logic [1:0] oh;
        oh = w ? 2'b10 : 2'b01;
        e = '0;
        e.resp = 1'b1;
        e.ws   = w;
        if (wr) begin
            e.ld = oh;
            e.sd = oh;
        end
        q.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        set_idx   = s;
        hit       = h;
        valid     = v;
        dirty     = 2'b00;
        tick();
        idle();
        tick();
    endtask

    task automatic do_miss(input logic [2:0] s, input logic wr,
                           input logic [1:0] v, input logic [1:0] d,
                           input logic vic, input logic wb,
                           input int wlat, input int rlat, input logic drop);
        ob_t e;
        logic [1:0] oh;
        oh = vic ? 2'b10 : 2'b01;
        if (wb) begin
            e = '0; e.pw = 1'b1; e.asrc = 1'b1; e.ws = vic;
            q.push_back(e);
            e.cd = oh;
            q.push_back(e);
        end
        e = '0; e.pr = 1'b1;
        q.push_back(e);
        e.ld = oh; e.lt = oh; e.cd = oh; e.ds = 1'b1;
        q.push_back(e);
        if (!drop) begin
            e = '0; e.resp = 1'b1; e.ws = vic;
            if (wr) begin
                e.ld = oh;
                e.sd = oh;
            end
            q.push_back(e);
        end
        mem_read  = ~wr;
        mem_write = wr;
        set_idx   = s;
        hit       = 2'b00;
        valid     = v;
        dirty     = d;
        tick();
        if (wb) begin
            if (drop) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            repeat (wlat - 1) tick();
            pmem_resp = 1'b1;
            tick();
            pmem_resp = 1'b0;
        end
        repeat (rlat - 1) tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        if (!drop) begin
            hit   = oh;
            valid = v | oh;
            dirty = d & ~oh;
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        ob_t e;
        rst_n     = 1'b0;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        set_idx   = 3'd0;
        hit       = 2'b01;
        valid     = 2'b01;
        dirty     = 2'b00;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(cur_out()), 32'd0);
        tick();
        idle();
        valid = 2'b00;
        rst_n = 1'b1;
        tick();
        // read miss, empty set 2, allocate way 0, LRU[2]=1
        do_miss(3'd2, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2, 4, 1'b0);
        // LRU[2]=1 makes way 1 the victim, then LRU[2]=0
        do_miss(3'd2, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2, 2, 1'b0);
        // set 5: read hit w0 (LRU=1), write hit w1 (LRU=0), miss -> w0
        do_hit(3'd5, 1'b1, 1'b0, 2'b01, 2'b11, 1'b0);
        do_hit(3'd5, 1'b0, 1'b1, 2'b10, 2'b11, 1'b1);
        do_miss(3'd5, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2, 3, 1'b0);
        // read+write together acts as write; double hit picks way 0
        do_hit(3'd6, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0);
        do_hit(3'd7, 1'b1, 1'b0, 2'b11, 2'b11, 1'b0);
        // set 3: LRU=1 then dirty way 1 victim -> writeback
        do_hit(3'd3, 1'b1, 1'b0, 2'b01, 2'b11, 1'b0);
        do_miss(3'd3, 1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 3, 2, 1'b0);
        // write miss into invalid way 1 of set 1
        do_miss(3'd1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 2, 2, 1'b0);
        // tags A, B, C on set 0: victims 0, 1, 0
        do_miss(3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2, 2, 1'b0);
        do_miss(3'd0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2, 2, 1'b0);
        do_miss(3'd0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2, 2, 1'b0);
        // invalid-but-dirty way 0 is allocated without writeback
        do_miss(3'd4, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 2, 2, 1'b0);
        // request dropped during writeback: finish both transfers, no resp
        do_miss(3'd3, 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 3, 2, 1'b1);
        // reset while allocating
        e = '0; e.pr = 1'b1;
        q.push_back(e);
        mem_read = 1'b1;
        set_idx  = 3'd4;
        valid    = 2'b00;
        dirty    = 2'b00;
        tick();
        tick();
        chk("alloc_pmem_read", 32'(pmem_read), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pmem_read", 32'(pmem_read), 32'd0);
        hit   = 2'b01;
        valid = 2'b01;
        @(negedge clk);
        chk("rst_held_outputs", 32'(cur_out()), 32'd0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        // LRU[5] and LRU[0] were 1 before reset; now way 0 is victim
        do_miss(3'd5, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2, 2, 1'b0);
        do_miss(3'd0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2, 2, 1'b0);
        repeat (3) tick();
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
